// File: rtl/uart_resp_pkg.sv
// Shared constants and FSM state encoding for the UART register-access responder.
package uart_resp_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned STATE_W = 4;

  localparam logic [BYTE_W-1:0] OP_WRITE = 8'h57;
  localparam logic [BYTE_W-1:0] OP_READ  = 8'h52;
  localparam logic [BYTE_W-1:0] RSP_ACK  = 8'h4B;
  localparam logic [BYTE_W-1:0] RSP_ERR  = 8'h3F;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_BUS_WR,
    S_BUS_RD,
    S_RD_CAP,
    S_SEND,
    S_TX_HOLD,
    S_TX_WAIT
  } state_t;

endpackage

// File: rtl/uart_byte_timeout.sv
// Saturating inter-byte idle counter; expired once TIMEOUT_CYCLES enabled cycles pass without a clear.
module uart_byte_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  assign expired = (count == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_reg_responder.sv
// Decodes 'W'/'R' register commands from received bytes, drives the register bus
// and returns one reply byte per command through the transmitter handshake.
module uart_reg_responder
  import uart_resp_pkg::*;
#(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_ready,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic              bus_we,
  output logic              bus_re,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [BYTE_W-1:0] bus_wdata,
  input  logic [BYTE_W-1:0] bus_rdata,
  output logic              overrun,
  output logic              busy
);

  state_t              state, next_state;
  logic [BYTE_W-1:0]   opcode, opcode_next;
  logic [BYTE_W-1:0]   tx_data_next, bus_wdata_next;
  logic [ADDR_W-1:0]   bus_addr_next;
  logic                tx_start_next, overrun_next;
  logic                addr_ok, accepting, collecting, expired;

  assign addr_ok    = ((rx_data >> ADDR_W) == 8'd0);
  assign collecting = (state == S_GET_ADDR) || (state == S_GET_DATA);
  assign accepting  = (state == S_IDLE) || collecting;

  uart_byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_ready && accepting),
    .enable (collecting),
    .expired(expired)
  );

  // tx_start is a flop, so tx_busy is sampled the cycle before the start is presented.
  always_comb begin
    next_state     = state;
    opcode_next    = opcode;
    tx_data_next   = tx_data;
    bus_addr_next  = bus_addr;
    bus_wdata_next = bus_wdata;
    tx_start_next  = 1'b0;
    overrun_next   = rx_ready && !accepting;
    unique case (state)
      S_IDLE: begin
        if (rx_ready) begin
          opcode_next = rx_data;
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            next_state = S_GET_ADDR;
          end else begin
            tx_data_next  = RSP_ERR;
            tx_start_next = !tx_busy;
            next_state    = S_SEND;
          end
        end
      end
      S_GET_ADDR: begin
        if (rx_ready) begin
          if (!addr_ok) begin
            tx_data_next  = RSP_ERR;
            tx_start_next = !tx_busy;
            next_state    = S_SEND;
          end else begin
            bus_addr_next = rx_data[ADDR_W-1:0];
            next_state    = (opcode == OP_READ) ? S_BUS_RD : S_GET_DATA;
          end
        end else if (expired) begin
          next_state = S_IDLE;
        end
      end
      S_GET_DATA: begin
        if (rx_ready) begin
          bus_wdata_next = rx_data;
          next_state     = S_BUS_WR;
        end else if (expired) begin
          next_state = S_IDLE;
        end
      end
      S_BUS_WR: begin
        tx_data_next  = RSP_ACK;
        tx_start_next = !tx_busy;
        next_state    = S_SEND;
      end
      S_BUS_RD: next_state = S_RD_CAP;
      S_RD_CAP: begin
        tx_data_next  = bus_rdata;
        tx_start_next = !tx_busy;
        next_state    = S_SEND;
      end
      S_SEND: begin
        if (tx_start) next_state = S_TX_HOLD;
        else          tx_start_next = !tx_busy;
      end
      S_TX_HOLD: next_state = S_TX_WAIT;
      S_TX_WAIT: if (!tx_busy) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      opcode    <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      opcode    <= opcode_next;
      tx_start  <= tx_start_next;
      tx_data   <= tx_data_next;
      bus_we    <= (next_state == S_BUS_WR);
      bus_re    <= (next_state == S_BUS_RD);
      bus_addr  <= bus_addr_next;
      bus_wdata <= bus_wdata_next;
      overrun   <= overrun_next;
      busy      <= (next_state != S_IDLE);
    end
  end

endmodule

// File: doc/uart_reg_responder.md
# uart_reg_responder

Command-layer responder on the byte side of the UART endpoint. It consumes received bytes (`rx_data`/`rx_ready`), decodes a 2–3 byte register-access protocol, drives a simple register bus, and returns exactly one response byte per command through `tx_start`/`tx_data`, honouring `tx_busy`. It is the far-end client of the transceiver's byte interface: it turns a host UART link into register reads and writes.

## Interface
- `ADDR_W`, default 4: register bus address width; valid addresses are 0 to 2^ADDR_W−1.
- `TIMEOUT_CYCLES`, default 50000000: number of idle clocks allowed between bytes of one command.
- `clk`  in  1  system clock.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `rx_data`  in  8  received byte; valid only in the cycle `rx_ready`=1.
- `rx_ready`  in  1  one-cycle strobe per received byte.
- `tx_busy`  in  1  transmitter busy.
- `tx_start`  out  1  one-cycle request to send `tx_data`.
- `tx_data`  out  8  response byte; held stable from `tx_start` until the transmitter is idle again.
- `bus_we`  out  1  one-cycle write strobe.
- `bus_re`  out  1  one-cycle read strobe.
- `bus_addr`  out  ADDR_W  register address.
- `bus_wdata`  out  8  write data.
- `bus_rdata`  in  8  read data; valid the cycle after `bus_re`.
- `overrun`  out  1  one-cycle pulse when a byte is dropped.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Protocol:
  - Write: 0x57 ('W'), addr, data → bus write; reply 0x4B ('K').
  - Read: 0x52 ('R'), addr → bus read; reply the read byte.
  - Any other opcode → reply 0x3F ('?').
  - An address byte with bits above `ADDR_W` nonzero → reply 0x3F, with no bus access.
- FSM states: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_CAP, SEND, TX_HOLD, TX_WAIT.
  - IDLE: on `rx_ready`, latch the opcode. 'W' or 'R' → GET_ADDR. Otherwise load `tx_data`=0x3F → SEND.
  - GET_ADDR: on `rx_ready`:
    - bad address → `tx_data`=0x3F → SEND;
    - 'R' → latch `bus_addr` → BUS_RD;
    - 'W' → latch `bus_addr` → GET_DATA.
  - GET_DATA: on `rx_ready`, latch `bus_wdata` → BUS_WR.
  - BUS_WR: `bus_we`=1; load `tx_data`=0x4B → SEND.
  - BUS_RD: `bus_re`=1 → RD_CAP.
  - RD_CAP: `tx_data`←`bus_rdata` → SEND.
  - SEND: while `tx_busy`=1, stay. When `tx_busy`=0, assert `tx_start` for this cycle → TX_HOLD.
  - TX_HOLD: one cycle in which `tx_busy` is ignored → TX_WAIT.
  - TX_WAIT: when `tx_busy`=0 → IDLE.
- Timeout:
  - The counter clears on every accepted byte and counts only in GET_ADDR and GET_DATA.
  - After `TIMEOUT_CYCLES` consecutive cycles with no `rx_ready`, the FSM goes to IDLE on the next cycle, with no reply and no bus access.
  - Counter width is clog2(`TIMEOUT_CYCLES`+1); it saturates and never wraps.
- Overrun:
  - `rx_ready` in BUS_WR, BUS_RD, RD_CAP, SEND, TX_HOLD or TX_WAIT drops the byte.
  - `overrun` pulses for one cycle, one cycle later. The current command completes normally.
- Outputs are decoded from registered state and registers only; there is no combinational input→output path.
- Reset: all outputs are 0 and the state is IDLE immediately on assertion, including mid-transfer; `tx_start` drops at once. The first `clk` edge after deassertion is in IDLE.

## Timing
- Let N be the cycle of the final command byte's `rx_ready`.
- Write: `bus_we` at N+1; `tx_start` at N+2 if `tx_busy`=0.
- Read: `bus_re` at N+1; `bus_rdata` sampled at N+2; `tx_start` at N+3 if `tx_busy`=0.
- Bad opcode or bad address: `tx_start` at N+1 if `tx_busy`=0.
- Each `tx_start` is followed by at least two non-IDLE cycles (TX_HOLD, then TX_WAIT).
- The earliest next accepted byte is the cycle after TX_WAIT exits.
- `bus_addr` and `bus_wdata` stay stable from latch until the next command latches new values.

## Structure
- Shared package `uart_resp_pkg`: opcode constants (0x57, 0x52), reply constants (0x4B, 0x3F), and the FSM state enum.
- One sub-module: `uart_byte_timeout`, the saturating inter-byte counter with `clear`/`enable` inputs and an `expired` output.

## Test plan
- Write: rx bytes 0x57, 0x03, 0xA5 → one-cycle `bus_we` with addr 3 and wdata 0xA5 at N+1; `tx_start` with `tx_data`=0x4B at N+2.
- Read: rx 0x52, 0x03 with `bus_rdata`=0x5C → `bus_re` with addr 3 at N+1; `tx_start` with `tx_data`=0x5C at N+3.
- Errors:
  - rx 0x41 → reply 0x3F, no bus strobe.
  - rx 0x52, 0x13 (`ADDR_W`=4) → reply 0x3F, no `bus_re`.
- Timeout (`TIMEOUT_CYCLES`=100): rx 0x57, then silence for 100 cycles → IDLE, `busy`=0, no `tx_start`. A following 0x52, 0x01 completes normally.
- Backpressure/overrun: `tx_busy` held high 500 cycles during SEND → `tx_start` stays 0. A byte arriving during SEND → one `overrun` pulse, byte discarded, reply sent once `tx_busy` falls.
- Reset mid-read: assert `reset` in RD_CAP → all outputs 0 asynchronously. After release, a write 0x57, 0x00, 0xFF completes with reply 0x4B.
